// File: rtl/filtro_codigo.sv
// PS/2 scan-code filter: decodes E0/F0 prefixed sequences into key events
// and queues them in a small first-word-fall-through FIFO.
// Optional feature macro: FILTRO_CODIGO_MAKE_EN. When it is defined, make
// (press) events are queued. When it is undefined, only break (release)
// events are queued.
module filtro_codigo #(
  parameter int unsigned          DATA_W   = 8,
  parameter logic [DATA_W-1:0]    BRK_CODE = 8'hF0,
  parameter logic [DATA_W-1:0]    EXT_CODE = 8'hE0,
  parameter int unsigned          ADDR_W   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] Dato_rx,
  input  logic              rx_done_tick,
  input  logic              rd_en,
  output logic [DATA_W-1:0] code_out,
  output logic              ext_out,
  output logic              break_out,
  output logic              empty,
  output logic              full,
  output logic              overflow
);

  typedef enum logic [1:0] {StIdle, StExt, StBrk} state_t;

  localparam int unsigned EntryW = DATA_W + 2;
  localparam int unsigned Depth  = 2 ** ADDR_W;

  state_t            r_state;
  logic              r_ext_flag;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic              r_overflow;
  logic [EntryW-1:0] r_mem [Depth];

  state_t            w_state_next;
  logic              w_ext_flag_next;
  logic              w_evt_valid;
  logic              w_evt_ext;
  logic              w_evt_brk;
  logic              w_evt_push_req;
  logic              w_is_brk;
  logic              w_is_ext;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic [EntryW-1:0] w_head;

  assign w_is_brk = (Dato_rx == BRK_CODE);
  assign w_is_ext = (Dato_rx == EXT_CODE);

  // Decoder next state and event generation; only acts on received bytes.
  always_comb begin
    w_state_next    = r_state;
    w_ext_flag_next = r_ext_flag;
    w_evt_valid     = 1'b0;
    w_evt_ext       = 1'b0;
    w_evt_brk       = 1'b0;
    if (rx_done_tick) begin
      unique case (r_state)
        StIdle: begin
          if (w_is_ext) begin
            w_state_next = StExt;
          end else if (w_is_brk) begin
            w_state_next    = StBrk;
            w_ext_flag_next = 1'b0;
          end else begin
            w_evt_valid = 1'b1;
          end
        end
        StExt: begin
          if (w_is_brk) begin
            w_state_next    = StBrk;
            w_ext_flag_next = 1'b1;
          end else if (!w_is_ext) begin
            w_evt_valid  = 1'b1;
            w_evt_ext    = 1'b1;
            w_state_next = StIdle;
          end
        end
        StBrk: begin
          // A second prefix here is a protocol error: drop the byte.
          w_state_next = StIdle;
          if (!w_is_brk && !w_is_ext) begin
            w_evt_valid = 1'b1;
            w_evt_ext   = r_ext_flag;
            w_evt_brk   = 1'b1;
          end
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

`ifdef FILTRO_CODIGO_MAKE_EN
  assign w_evt_push_req = w_evt_valid;
`else
  assign w_evt_push_req = w_evt_valid & w_evt_brk;
`endif

  // Full when the wrap bits differ but the index bits match.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[ADDR_W] != r_rd_ptr[ADDR_W]) &&
                   (r_wr_ptr[ADDR_W-1:0] == r_rd_ptr[ADDR_W-1:0]);
  assign w_pop   = rd_en & ~w_empty;
  // A simultaneous pop frees the slot, so a write while full still lands.
  assign w_push  = w_evt_push_req & (~w_full | w_pop);

  // Decoder state, FIFO pointers and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_ext_flag <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ext_flag <= w_ext_flag_next;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_evt_push_req && w_full && !w_pop) r_overflow <= 1'b1;
    end
  end

  // Event storage; contents are don't-care until pointed at by a valid entry.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= {w_evt_ext, w_evt_brk, Dato_rx};
    end
  end

  assign w_head    = r_mem[r_rd_ptr[ADDR_W-1:0]];
  assign code_out  = w_empty ? '0 : w_head[DATA_W-1:0];
  assign break_out = w_empty ? 1'b0 : w_head[DATA_W];
  assign ext_out   = w_empty ? 1'b0 : w_head[DATA_W+1];
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;

endmodule
